background_layer: RTL and testbench

Parametrised background layer fetcher. It maps the current VGA raster coordinate to a position in a scrollable, optionally upscaled background image, and issues the word address to an external synchronous block RAM. It extracts the packed palette index from the returned word and drives 4-bit RGB through a writable 16-entry palette. It sits between the VGA timing generator and the top-level colour mux, replacing the fixed 480-wide, 8-pixels-per-word background path, and it compensates for RAM read latency with a matched pipeline.

---
 rtl/background_layer.sv | 129 ++++++++++++
 tb/tb_background_layer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/background_layer.sv
// rtl/background_layer.sv - scrollable, upscaled background fetcher with RAM-latency-matched pipeline and 16-entry palette
module background_layer #(
    parameter int IMG_W       = 320,
    parameter int IMG_H       = 240,
    parameter int BPP         = 4,
    parameter int WORD_W      = 32,
    parameter int ADDR_W      = 16,
    parameter int SCALE_SHIFT = 1,
    parameter int RAM_LAT     = 2
) (
    input  logic              clk_125MHz,
    input  logic              rst_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              de_in,
    input  logic              frame_start,
    input  logic [9:0]        scroll_x,
    input  logic [9:0]        scroll_y,
    input  logic              pal_we,
    input  logic [3:0]        pal_idx,
    input  logic [11:0]       pal_rgb,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic [3:0]        Bkg_Red,
    output logic [3:0]        Bkg_Green,
    output logic [3:0]        Bkg_Blue,
    output logic              de_out,
    output logic              bkg_transparent
);

    localparam int PPW        = WORD_W / BPP;
    localparam int ADDR_SHIFT = $clog2(PPW);
    localparam int SUB_W      = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int LIN_W      = 21;
    localparam logic [10:0] IMG_W11 = 11'(IMG_W);
    localparam logic [10:0] IMG_H11 = 11'(IMG_H);

    logic [9:0]       active_sx;
    logic [9:0]       active_sy;
    logic [10:0]      sum_x;
    logic [10:0]      sum_y;
    logic [10:0]      map_x;
    logic [10:0]      map_y;
    logic [9:0]       s1_sx;
    logic [9:0]       s1_sy;
    logic             s1_de;
    logic [LIN_W-1:0] lin;
    logic [SUB_W-1:0] sub_pipe [0:RAM_LAT];
    logic             de_pipe  [0:RAM_LAT];
    logic [3:0]       idx;
    logic [11:0]      palette  [0:15];

    // Source coordinate is always < image size, so one conditional subtract wraps.
    always_comb begin
        sum_x = 11'(DrawX >> SCALE_SHIFT) + {1'b0, active_sx};
        sum_y = 11'(DrawY >> SCALE_SHIFT) + {1'b0, active_sy};
        map_x = (sum_x >= IMG_W11) ? sum_x - IMG_W11 : sum_x;
        map_y = (sum_y >= IMG_H11) ? sum_y - IMG_H11 : sum_y;
        lin   = LIN_W'(s1_sy) * LIN_W'(IMG_W) + LIN_W'(s1_sx);
    end

    always_ff @(posedge clk_125MHz) begin
        if (!rst_n) begin
            active_sx <= '0;
            active_sy <= '0;
            s1_sx     <= '0;
            s1_sy     <= '0;
            s1_de     <= 1'b0;
            mem_addr  <= '0;
            for (int i = 0; i <= RAM_LAT; i++) begin
                sub_pipe[i] <= '0;
                de_pipe[i]  <= 1'b0;
            end
        end else begin
            if (frame_start) begin
                active_sx <= ({1'b0, scroll_x} >= IMG_W11) ? 10'd0 : scroll_x;
                active_sy <= ({1'b0, scroll_y} >= IMG_H11) ? 10'd0 : scroll_y;
            end
            s1_sx       <= map_x[9:0];
            s1_sy       <= map_y[9:0];
            s1_de       <= de_in;
            mem_addr    <= ADDR_W'(lin >> ADDR_SHIFT);
            sub_pipe[0] <= SUB_W'(lin % LIN_W'(PPW));
            de_pipe[0]  <= s1_de;
            // Sub-word select and valid ride alongside the RAM read latency.
            for (int i = 1; i <= RAM_LAT; i++) begin
                sub_pipe[i] <= sub_pipe[i-1];
                de_pipe[i]  <= de_pipe[i-1];
            end
        end
    end

    always_comb begin
        idx = '0;
        idx[BPP-1:0] = mem_rdata[sub_pipe[RAM_LAT]*BPP +: BPP];
    end

    always_ff @(posedge clk_125MHz) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                palette[i] <= {i[3:0], i[3:0], i[3:0]};
            end
        end else if (pal_we) begin
            palette[pal_idx] <= pal_rgb;
        end
    end

    // Reading palette here sees the pre-write value on a same-cycle write.
    always_ff @(posedge clk_125MHz) begin
        if (!rst_n) begin
            Bkg_Red         <= '0;
            Bkg_Green       <= '0;
            Bkg_Blue        <= '0;
            de_out          <= 1'b0;
            bkg_transparent <= 1'b0;
        end else if (de_pipe[RAM_LAT]) begin
            {Bkg_Red, Bkg_Green, Bkg_Blue} <= palette[idx];
            de_out          <= 1'b1;
            bkg_transparent <= (idx == 4'd0);
        end else begin
            Bkg_Red         <= '0;
            Bkg_Green       <= '0;
            Bkg_Blue        <= '0;
            de_out          <= 1'b0;
            bkg_transparent <= 1'b0;
        end
    end

endmodule

// File: tb/tb_background_layer.sv
// tb/tb_background_layer.sv - directed self-checking bench for background_layer with a 2-cycle RAM model
module tb_background_layer;

    logic        clk_125MHz = 1'b0;
    logic        rst_n;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        de_in;
    logic        frame_start;
    logic [9:0]  scroll_x;
    logic [9:0]  scroll_y;
    logic        pal_we;
    logic [3:0]  pal_idx;
    logic [11:0] pal_rgb;
    logic [15:0] mem_addr;
    logic [31:0] mem_rdata;
    logic [3:0]  Bkg_Red;
    logic [3:0]  Bkg_Green;
    logic [3:0]  Bkg_Blue;
    logic        de_out;
    logic        bkg_transparent;

    int checks = 0;
    int errors = 0;

    logic [31:0] ram [0:9599];
    logic [31:0] rd1;

    background_layer dut (
        .clk_125MHz      (clk_125MHz),
        .rst_n           (rst_n),
        .DrawX           (DrawX),
        .DrawY           (DrawY),
        .de_in           (de_in),
        .frame_start     (frame_start),
        .scroll_x        (scroll_x),
        .scroll_y        (scroll_y),
        .pal_we          (pal_we),
        .pal_idx         (pal_idx),
        .pal_rgb         (pal_rgb),
        .mem_addr        (mem_addr),
        .mem_rdata       (mem_rdata),
        .Bkg_Red         (Bkg_Red),
        .Bkg_Green       (Bkg_Green),
        .Bkg_Blue        (Bkg_Blue),
        .de_out          (de_out),
        .bkg_transparent (bkg_transparent)
    );

    always #4 clk_125MHz = ~clk_125MHz;

    // Synchronous RAM, two-cycle read latency.
    always @(posedge clk_125MHz) begin
        rd1       <= (mem_addr < 16'd9600) ? ram[mem_addr] : 32'h0;
        mem_rdata <= rd1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One visible pixel, then blanking; optional palette write at the colour edge.
    task automatic fetch(input string tag, input logic [9:0] x, input logic [9:0] y,
                         input logic [15:0] exp_addr, input logic [11:0] exp_rgb,
                         input logic exp_t, input logic wr, input logic [3:0] widx,
                         input logic [11:0] wrgb);
        @(negedge clk_125MHz);
        DrawX = x;
        DrawY = y;
        de_in = 1'b1;
        @(negedge clk_125MHz);
        de_in = 1'b0;
        @(negedge clk_125MHz);
        check({tag, "_addr"}, {16'h0, mem_addr}, {16'h0, exp_addr});
        @(negedge clk_125MHz);
        check({tag, "_early_de"}, {31'h0, de_out}, 32'h0);
        @(negedge clk_125MHz);
        if (wr) begin
            pal_we  = 1'b1;
            pal_idx = widx;
            pal_rgb = wrgb;
        end
        @(negedge clk_125MHz);
        pal_we = 1'b0;
        check({tag, "_rgb"}, {20'h0, Bkg_Red, Bkg_Green, Bkg_Blue}, {20'h0, exp_rgb});
        check({tag, "_de"}, {31'h0, de_out}, 32'h1);
        check({tag, "_transp"}, {31'h0, bkg_transparent}, {31'h0, exp_t});
    endtask

    task automatic latch_scroll(input logic [9:0] sx, input logic [9:0] sy);
        @(negedge clk_125MHz);
        scroll_x    = sx;
        scroll_y    = sy;
        frame_start = 1'b1;
        @(negedge clk_125MHz);
        frame_start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 9600; i++) ram[i] = 32'h0;
        ram[0]    = 32'h76543210;
        ram[41]   = 32'h00000900;
        ram[9599] = 32'hA0000000;

        rst_n = 1'b0; de_in = 1'b1; DrawX = 10'd10; DrawY = 10'd0;
        frame_start = 1'b0; scroll_x = '0; scroll_y = '0;
        pal_we = 1'b0; pal_idx = '0; pal_rgb = '0;
        repeat (3) @(negedge clk_125MHz);
        check("rst_rgb", {20'h0, Bkg_Red, Bkg_Green, Bkg_Blue}, 32'h0);
        check("rst_de", {31'h0, de_out}, 32'h0);
        check("rst_addr", {16'h0, mem_addr}, 32'h0);
        check("rst_transp", {31'h0, bkg_transparent}, 32'h0);
        rst_n = 1'b1;
        de_in = 1'b0;
        repeat (6) @(negedge clk_125MHz);

        fetch("pal5_reset", 10'd10, 10'd0, 16'd0, 12'h555, 1'b0, 1'b0, 4'd0, 12'h0);
        fetch("basic", 10'd2, 10'd0, 16'd0, 12'h111, 1'b0, 1'b0, 4'd0, 12'h0);
        fetch("idx0", 10'd0, 10'd0, 16'd0, 12'h000, 1'b1, 1'b0, 4'd0, 12'h0);
        fetch("mid", 10'd20, 10'd2, 16'd41, 12'h999, 1'b0, 1'b0, 4'd0, 12'h0);
        fetch("last", 10'd638, 10'd479, 16'd9599, 12'hAAA, 1'b0, 1'b0, 4'd0, 12'h0);

        @(negedge clk_125MHz);
        pal_we = 1'b1; pal_idx = 4'd3; pal_rgb = 12'hF80;
        @(negedge clk_125MHz);
        pal_we = 1'b0;
        fetch("pal3", 10'd6, 10'd0, 16'd0, 12'hF80, 1'b0, 1'b0, 4'd0, 12'h0);
        fetch("rbw_old", 10'd8, 10'd0, 16'd0, 12'h444, 1'b0, 1'b1, 4'd4, 12'h123);
        fetch("rbw_new", 10'd8, 10'd0, 16'd0, 12'h123, 1'b0, 1'b0, 4'd0, 12'h0);

        latch_scroll(10'd319, 10'd1);
        fetch("wrap0", 10'd2, 10'd479, 16'd0, 12'h000, 1'b1, 1'b0, 4'd0, 12'h0);
        fetch("wrap1", 10'd4, 10'd479, 16'd0, 12'h111, 1'b0, 1'b0, 4'd0, 12'h0);
        scroll_x = 10'd5;
        fetch("midframe", 10'd4, 10'd479, 16'd0, 12'h111, 1'b0, 1'b0, 4'd0, 12'h0);

        latch_scroll(10'd400, 10'd0);
        fetch("clamp", 10'd6, 10'd0, 16'd0, 12'hF80, 1'b0, 1'b0, 4'd0, 12'h0);

        @(negedge clk_125MHz);
        DrawX = 10'd2; DrawY = 10'd0; de_in = 1'b1;
        repeat (6) @(negedge clk_125MHz);
        check("stream_de", {31'h0, de_out}, 32'h1);
        rst_n = 1'b0;
        @(negedge clk_125MHz);
        rst_n = 1'b1;
        check("rst_mid_de0", {31'h0, de_out}, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk_125MHz);
            check($sformatf("rst_mid_de%0d", i), {31'h0, de_out}, 32'h0);
        end
        @(negedge clk_125MHz);
        check("rst_mid_resume", {31'h0, de_out}, 32'h1);
        check("rst_mid_rgb", {20'h0, Bkg_Red, Bkg_Green, Bkg_Blue}, 32'h111);
        de_in = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
